// File: rtl/jtag_pkg.sv
// Purpose: shared TAP state encoding, default opcodes and IR capture pattern.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_pkg;

  // Standard 1149.1 state encoding; tap_state exposes these values directly.
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  localparam logic [3:0] DEF_OP_EXTEST = 4'h0;
  localparam logic [3:0] DEF_OP_SAMPLE = 4'h1;
  localparam logic [3:0] DEF_OP_IDCODE = 4'h2;

  // Loaded into the IR shift register in Capture-IR; upper bits are zero.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// Purpose: 16-state TAP controller state register and next-state logic.
// Latency: state advances on every tck rising edge from the sampled tms.
// Backpressure: none; the TAP is paced purely by tck/tms.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output logic [3:0] state,
  output logic [3:0] next_state
);

  tap_state_t cur_state;
  tap_state_t nxt_state;

  // State register; trst_n forces Test-Logic-Reset asynchronously.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) cur_state <= TLR;
    else         cur_state <= nxt_state;
  end

  // Next-state decode from tms.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      TLR:    nxt_state = tms ? TLR    : RTI;
      RTI:    nxt_state = tms ? SEL_DR : RTI;
      SEL_DR: nxt_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt_state = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt_state = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt_state = tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt_state = tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt_state = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt_state = tms ? SEL_DR : RTI;
      SEL_IR: nxt_state = tms ? TLR    : CAP_IR;
      CAP_IR: nxt_state = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt_state = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt_state = tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt_state = tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt_state = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt_state = tms ? SEL_DR : RTI;
    endcase
  end

  assign state      = cur_state;
  assign next_state = nxt_state;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// Purpose: TAP controller owning IR, bypass and IDCODE registers and driving BSR controls.
// Latency: controls decode the current state; tdo/tdo_en lag by half a tck (falling edge).
// Backpressure: none; all transfers are paced by tck/tms.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(DEF_OP_EXTEST),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(DEF_OP_SAMPLE),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(DEF_OP_IDCODE),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS  = '1
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_so,
  output logic                tdo,
  output logic                tdo_en,
  output logic                bsr_si,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                mode,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out
);

  logic [3:0]          state;
  logic [3:0]          next_state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass_reg;
  logic [31:0]         id_reg;
  logic                to_tlr;
  logic                bsr_sel;
  logic                id_sel;
  logic                byp_sel;
  logic                dr_lsb;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms        (tms),
    .state      (state),
    .next_state (next_state)
  );

  // Entering TLR behaves like a synchronous reset of every TAP register.
  assign to_tlr = (next_state == TLR);

  // DR selection: anything that is not BSR or IDCODE falls back to bypass.
  assign bsr_sel = (ir_out == OP_EXTEST) || (ir_out == OP_SAMPLE);
  assign id_sel  = (ir_out == OP_IDCODE) && !bsr_sel;
  assign byp_sel = (ir_out == OP_BYPASS) || !(bsr_sel || id_sel);
  assign dr_lsb  = bsr_sel ? bsr_so : (id_sel ? id_reg[0] : bypass_reg);

  assign tap_state  = state;
  assign bsr_si     = tdi;
  assign capture_dr = bsr_sel && (state == CAP_DR);
  assign shift_dr   = bsr_sel && (state == SH_DR);
  assign update_dr  = bsr_sel && (state == UPD_DR);
  assign mode       = (ir_out == OP_EXTEST);

  // Instruction path: capture pattern, LSB-first shift, copy to ir_out in Update-IR.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr  <= '0;
      ir_out <= OP_IDCODE;
    end else if (to_tlr) begin
      ir_sr  <= '0;
      ir_out <= OP_IDCODE;
    end else begin
      if (state == CAP_IR)     ir_sr <= IR_WIDTH'(IR_CAPTURE);
      else if (state == SH_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
      if (state == UPD_IR)     ir_out <= ir_sr;
    end
  end

  // Bypass and IDCODE data registers; Pause/Exit states leave them untouched.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bypass_reg <= 1'b0;
      id_reg     <= IDCODE_VAL;
    end else if (to_tlr) begin
      bypass_reg <= 1'b0;
      id_reg     <= IDCODE_VAL;
    end else if (state == CAP_DR) begin
      if (id_sel)  id_reg     <= IDCODE_VAL;
      if (byp_sel) bypass_reg <= 1'b0;
    end else if (state == SH_DR) begin
      if (id_sel)  id_reg     <= {tdi, id_reg[31:1]};
      if (byp_sel) bypass_reg <= tdi;
    end
  end

  // TDO retimed on the falling edge so it is stable at the next rising edge.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == SH_IR) || (state == SH_DR);
      if (state == SH_IR)      tdo <= ir_sr[0];
      else if (state == SH_DR) tdo <= dr_lsb;
      else                     tdo <= 1'b0;
    end
  end

endmodule
